fwd_hazard_unit: RTL and testbench
==================================

# fwd_hazard_unit

Pipeline forwarding and load-use hazard controller for the 5-stage CPU core. Tracks destination-register metadata of instructions in the EX, MEM and WB stages and generates the 2-bit select codes that drive the EX-stage operand 3-input multiplexers. Detects load-use dependencies, requests a one-cycle ID stall with an EX bubble, and counts stall cycles for performance reporting. Sits beside the ID/EX pipeline registers and consumes decoded fields from ID.

## Interface
- `REG_AW`, 5, register-index width
- `CNT_W`, 16, stall counter width
- `clk`  in  1  core clock; all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `id_valid`  in  1  ID holds a real instruction
- `id_rs1`, `id_rs2`  in  REG_AW  ID source register indices
- `id_use_rs1`, `id_use_rs2`  in  1  instruction actually reads rs1/rs2
- `id_rd`  in  REG_AW  ID destination index
- `id_reg_write`  in  1  ID instruction writes rd
- `id_mem_read`  in  1  ID instruction is a load
- `flush`  in  1  branch/jump taken in EX; kill ID instruction
- `freeze`  in  1  global pipeline hold (memory wait); no state changes
- `fwd_a`, `fwd_b`  out  2  operand select for EX rs1/rs2 muxes
- `stall`  out  1  hold PC and IF/ID, insert bubble into EX
- `stall_count`  out  CNT_W  saturating count of stall cycles

## Operation
- Select encoding (matches mux select order): 0 = register file, 1 = MEM-stage result, 2 = WB-stage result; code 3 never produced.
- Per-stage record (EX, MEM, WB): valid, rd, reg_write, mem_read; EX additionally holds rs1, rs2, use_rs1, use_rs2.
- Each unfrozen edge: WB <= MEM, MEM <= EX, EX <= ID record, or bubble (valid=0) when `stall` or `flush` or `!id_valid`.
- `fwd_a`: 1 if MEM.valid & MEM.reg_write & MEM.rd != 0 & MEM.rd == EX.rs1 & EX.use_rs1; else 2 if same test against WB; else 0. `fwd_b` identical with rs2. MEM beats WB. Both 0 when EX.valid=0.
- Register x0 never forwarded and never causes a stall.
- `stall` = id_valid & EX.valid & EX.mem_read & EX.rd != 0 & ((id_use_rs1 & id_rs1 == EX.rd) | (id_use_rs2 & id_rs2 == EX.rd)) & !flush.
- `flush` dominates `stall`: stall output forced 0, EX receives bubble.
- `freeze`=1: all stage records and `stall_count` hold; `fwd_*` and `stall` remain combinational from held state.
- `stall_count` increments by 1 on each edge with stall=1 & freeze=0; saturates at all-ones.

## Timing
- Reset (rst_n low, any time, asynchronous): all stage valid bits 0, stored fields 0; therefore fwd_a=0, fwd_b=0, stall=0, stall_count=0 immediately. Reset mid-stall drops stall at once.
- `fwd_*` and `stall` are combinational (same cycle) from current-stage state and ID inputs; zero latency.
- Load-use: exactly one stall cycle per dependent instruction; next cycle the load is in MEM, dependency resolves through WB forward (select 2) one cycle later, stall deasserted.
- ALU-to-dependent back-to-back: select 1 in the cycle the consumer is in EX; no stall.
- Stall and freeze same cycle: no bubble inserted, no count; stall re-evaluated next cycle.

## Structure
- Shared package `cpu_pkg`: `FWD_RF`, `FWD_MEM`, `FWD_WB` constants; stage-record typedef; `REG_AW` default.
- One sub-module `hazard_stage_reg`: record register with async active-low clear, enable (=!freeze), bubble input; instantiated for EX, MEM, WB.
- Forwarding compare and stall detect stay in the top as combinational logic.

## Test plan
- `add x5,..` then `sub x6,x5,x1` back-to-back -> fwd_a=1 while sub in EX, stall=0.
- `add x5`, unrelated instr, `or x7,x2,x5` -> fwd_b=2; with x5 written in both MEM and WB -> fwd_a=1 (MEM priority).
- `lw x8` then `add x9,x8,x8` -> stall=1 for one cycle, EX bubble, then fwd_a=fwd_b=2; stall_count 0->1.
- Writes/reads of x0 in every combination -> fwd_a=fwd_b=0, stall=0.
- Load-use with flush=1 same cycle -> stall=0, EX bubble, stall_count unchanged; freeze=1 for 3 cycles during stall -> state and count held.
- Preload stall_count to max via 2^CNT_W stalls -> stays all-ones; assert rst_n=0 mid-stall -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared core definitions: forwarding select codes and the
// per-stage destination/source record tracked by the hazard unit.
package cpu_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              mem_read;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              use_rs1;
        logic              use_rs2;
    } stage_rec_t;

    // Producer in stage s can supply register rs (x0 excluded)
    function automatic logic fwd_hit(
        input stage_rec_t        s,
        input logic [REG_AW-1:0] rs
    );
        return s.valid & s.reg_write
             & (s.rd != '0) & (s.rd == rs);
    endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One pipeline-stage metadata record with async clear,
// hold enable and bubble insertion.
module hazard_stage_reg
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       bubble,
    input  stage_rec_t d,
    output stage_rec_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= bubble ? '0 : d;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX operand forwarding selects, load-use stall detect and
// saturating stall-cycle counter for the 5-stage core.
module fwd_hazard_unit #(
    parameter int REG_AW = cpu_pkg::REG_AW,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    input  logic              freeze,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_count
);

    import cpu_pkg::*;

    stage_rec_t id_rec;
    stage_rec_t ex_q;
    stage_rec_t mem_q;
    stage_rec_t wb_q;

    logic en;
    logic ex_bubble;

    assign en = ~freeze;

    always_comb begin
        id_rec           = '0;
        id_rec.valid     = id_valid;
        id_rec.rd        = id_rd;
        id_rec.reg_write = id_reg_write;
        id_rec.mem_read  = id_mem_read;
        id_rec.rs1       = id_rs1;
        id_rec.rs2       = id_rs2;
        id_rec.use_rs1   = id_use_rs1;
        id_rec.use_rs2   = id_use_rs2;
    end

    // Stall and flush both turn the EX slot into a bubble
    assign ex_bubble = stall | flush | ~id_valid;

    hazard_stage_reg u_ex (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .bubble (ex_bubble),
        .d      (id_rec),
        .q      (ex_q)
    );

    hazard_stage_reg u_mem (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .bubble (1'b0),
        .d      (ex_q),
        .q      (mem_q)
    );

    hazard_stage_reg u_wb (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .bubble (1'b0),
        .d      (mem_q),
        .q      (wb_q)
    );

    logic a_mem;
    logic a_wb;
    logic b_mem;
    logic b_wb;

    assign a_mem = ex_q.valid & ex_q.use_rs1
                 & fwd_hit(mem_q, ex_q.rs1);
    assign a_wb  = ex_q.valid & ex_q.use_rs1
                 & fwd_hit(wb_q, ex_q.rs1);
    assign b_mem = ex_q.valid & ex_q.use_rs2
                 & fwd_hit(mem_q, ex_q.rs2);
    assign b_wb  = ex_q.valid & ex_q.use_rs2
                 & fwd_hit(wb_q, ex_q.rs2);

    // MEM is younger than WB, so it wins
    always_comb begin
        fwd_a = FWD_RF;
        priority case (1'b1)
            a_mem:   fwd_a = FWD_MEM;
            a_wb:    fwd_a = FWD_WB;
            default: fwd_a = FWD_RF;
        endcase
    end

    always_comb begin
        fwd_b = FWD_RF;
        priority case (1'b1)
            b_mem:   fwd_b = FWD_MEM;
            b_wb:    fwd_b = FWD_WB;
            default: fwd_b = FWD_RF;
        endcase
    end

    logic ld_in_ex;
    logic ld_dep;

    assign ld_in_ex = ex_q.valid & ex_q.mem_read
                    & (ex_q.rd != '0);
    assign ld_dep   = (id_use_rs1 & (id_rs1 == ex_q.rd))
                    | (id_use_rs2 & (id_rs2 == ex_q.rd));
    assign stall    = id_valid & ld_in_ex & ld_dep & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall & en & ~&stall_count) begin
            stall_count <= stall_count + 1'b1;
        end
    end

    logic unused_wb;
    assign unused_wb = ^{wb_q.mem_read, wb_q.rs1, wb_q.rs2,
                         wb_q.use_rs1, wb_q.use_rs2};

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed and randomized checks of fwd_hazard_unit against an
// instruction-history reference model.
module tb_fwd_hazard_unit;

    localparam int AW = 5;
    localparam int CW = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid;
    logic [AW-1:0] id_rs1;
    logic [AW-1:0] id_rs2;
    logic          id_use_rs1;
    logic          id_use_rs2;
    logic [AW-1:0] id_rd;
    logic          id_reg_write;
    logic          id_mem_read;
    logic          flush;
    logic          freeze;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;
    logic          stall;
    logic [CW-1:0] stall_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.REG_AW(AW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .freeze       (freeze),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .stall        (stall),
        .stall_count  (stall_count)
    );

    // Model: the three instructions issued ahead of ID,
    // index = distance from EX (0 = EX, 1 = MEM, 2 = WB)
    typedef struct {
        bit v;
        int rd;
        bit rw;
        bit mr;
        int rs1;
        int rs2;
        bit u1;
        bit u2;
    } ins_t;

    ins_t pipe[3];
    int   m_cnt;

    function automatic ins_t empty_ins();
        ins_t e;
        e = '{default: 0};
        return e;
    endfunction

    function automatic ins_t id_ins();
        ins_t e;
        e.v   = 1'b1;
        e.rd  = int'(id_rd);
        e.rw  = id_reg_write;
        e.mr  = id_mem_read;
        e.rs1 = int'(id_rs1);
        e.rs2 = int'(id_rs2);
        e.u1  = id_use_rs1;
        e.u2  = id_use_rs2;
        return e;
    endfunction

    function automatic int m_fwd(int rs, bit u);
        if (!pipe[0].v || !u || rs == 0) return 0;
        for (int k = 1; k <= 2; k++)
            if (pipe[k].v && pipe[k].rw && pipe[k].rd == rs)
                return k;
        return 0;
    endfunction

    function automatic bit m_stall();
        int r;
        r = pipe[0].rd;
        if (!id_valid || flush) return 0;
        if (!pipe[0].v || !pipe[0].mr || r == 0) return 0;
        return (id_use_rs1 && int'(id_rs1) == r) ||
               (id_use_rs2 && int'(id_rs2) == r);
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 3; k++) pipe[k] = empty_ins();
        m_cnt = 0;
    endtask

    task automatic model_edge();
        bit s;
        s = m_stall();
        if (!freeze) begin
            if (s && m_cnt < CMAX) m_cnt++;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = (s || flush || !id_valid) ? empty_ins()
                                                : id_ins();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_id(bit v, int rs1, bit u1, int rs2, bit u2,
                          int rd, bit rw, bit mr);
        id_valid     = v;
        id_rs1       = rs1[AW-1:0];
        id_use_rs1   = u1;
        id_rs2       = rs2[AW-1:0];
        id_use_rs2   = u2;
        id_rd        = rd[AW-1:0];
        id_reg_write = rw;
        id_mem_read  = mr;
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        flush  = 1'b0;
        freeze = 1'b0;
        idle();
        rst_n = 1'b0;
        #2;
        model_clear();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        flush  = 1'b0;
        freeze = 1'b0;
        set_id(1, 3, 1, 4, 1, 5, 1, 1);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (fwd_a !== 2'd0) begin n_bad++;
            $display("FAIL reset_fwd_a got=%0d want=0", fwd_a); end
        n_cmp++; if (fwd_b !== 2'd0) begin n_bad++;
            $display("FAIL reset_fwd_b got=%0d want=0", fwd_b); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++;
            $display("FAIL reset_stall got=%0d want=0", stall); end
        n_cmp++; if (stall_count !== '0) begin n_bad++;
            $display("FAIL reset_count got=%0d want=0", stall_count); end
        model_clear();
        rst_n = 1'b1;
        idle();
        tick();
    endtask

    // add x5 ; sub x6,x5,x1
    task automatic test_alu_fwd();
        do_reset();
        set_id(1, 1, 1, 2, 1, 5, 1, 0);
        tick();
        set_id(1, 5, 1, 1, 1, 6, 1, 0);
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++;
            $display("FAIL alu_stall got=%0d want=0", stall); end
        tick();
        idle();
        #1;
        n_cmp++; if (fwd_a !== 2'd1) begin n_bad++;
            $display("FAIL alu_fwd_a got=%0d want=1", fwd_a); end
        n_cmp++; if (fwd_b !== 2'd0) begin n_bad++;
            $display("FAIL alu_fwd_b got=%0d want=0", fwd_b); end
    endtask

    task automatic test_wb_fwd();
        do_reset();
        set_id(1, 1, 1, 2, 1, 5, 1, 0);
        tick();
        set_id(1, 4, 1, 0, 0, 3, 1, 0);
        tick();
        set_id(1, 2, 1, 5, 1, 7, 1, 0);
        tick();
        idle();
        #1;
        n_cmp++; if (fwd_b !== 2'd2) begin n_bad++;
            $display("FAIL wb_fwd_b got=%0d want=2", fwd_b); end
        n_cmp++; if (fwd_a !== 2'd0) begin n_bad++;
            $display("FAIL wb_fwd_a got=%0d want=0", fwd_a); end
        do_reset();
        set_id(1, 1, 1, 2, 1, 5, 1, 0);
        tick();
        set_id(1, 3, 1, 4, 1, 5, 1, 0);
        tick();
        set_id(1, 5, 1, 0, 1, 6, 1, 0);
        tick();
        idle();
        #1;
        n_cmp++; if (fwd_a !== 2'd1) begin n_bad++;
            $display("FAIL prio_fwd_a got=%0d want=1", fwd_a); end
        n_cmp++; if (fwd_b !== 2'd0) begin n_bad++;
            $display("FAIL prio_fwd_b got=%0d want=0", fwd_b); end
    endtask

    // lw x8 ; add x9,x8,x8
    task automatic test_load_use();
        do_reset();
        set_id(1, 1, 1, 0, 0, 8, 1, 1);
        tick();
        set_id(1, 8, 1, 8, 1, 9, 1, 0);
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_bad++;
            $display("FAIL lu_stall got=%0d want=1", stall); end
        tick();
        n_cmp++; if (stall !== 1'b0) begin n_bad++;
            $display("FAIL lu_stall_drop got=%0d want=0", stall); end
        n_cmp++; if (fwd_a !== 2'd0) begin n_bad++;
            $display("FAIL lu_bubble_fwd_a got=%0d want=0", fwd_a); end
        n_cmp++; if (stall_count !== 8'd1) begin n_bad++;
            $display("FAIL lu_count got=%0d want=1", stall_count); end
        tick();
        idle();
        #1;
        n_cmp++; if (fwd_a !== 2'd2) begin n_bad++;
            $display("FAIL lu_fwd_a got=%0d want=2", fwd_a); end
        n_cmp++; if (fwd_b !== 2'd2) begin n_bad++;
            $display("FAIL lu_fwd_b got=%0d want=2", fwd_b); end
    endtask

    task automatic test_x0();
        for (int mr = 0; mr < 2; mr++) begin
            for (int d = 1; d <= 2; d++) begin
                do_reset();
                set_id(1, 1, 1, 2, 1, 0, 1, mr[0]);
                tick();
                if (d == 2) begin
                    set_id(1, 3, 1, 4, 1, 7, 1, 0);
                    tick();
                end
                set_id(1, 0, 1, 0, 1, 9, 1, 0);
                #1;
                n_cmp++; if (stall !== 1'b0) begin n_bad++;
                    $display("FAIL x0_stall mr=%0d d=%0d got=%0d want=0",
                             mr, d, stall); end
                tick();
                idle();
                #1;
                n_cmp++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin
                    n_bad++;
                    $display("FAIL x0_fwd mr=%0d d=%0d got=%0d/%0d want=0/0",
                             mr, d, fwd_a, fwd_b); end
            end
        end
    endtask

    task automatic test_flush_freeze();
        do_reset();
        set_id(1, 1, 1, 0, 0, 8, 1, 1);
        tick();
        set_id(1, 8, 1, 2, 1, 9, 1, 0);
        flush = 1'b1;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++;
            $display("FAIL flush_stall got=%0d want=0", stall); end
        tick();
        flush = 1'b0;
        idle();
        #1;
        n_cmp++; if (fwd_a !== 2'd0) begin n_bad++;
            $display("FAIL flush_bubble got=%0d want=0", fwd_a); end
        n_cmp++; if (stall_count !== 8'd0) begin n_bad++;
            $display("FAIL flush_count got=%0d want=0", stall_count); end
        do_reset();
        set_id(1, 1, 1, 0, 0, 8, 1, 1);
        tick();
        set_id(1, 8, 1, 2, 1, 9, 1, 0);
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (stall !== 1'b1 || stall_count !== 8'd0) begin
                n_bad++;
                $display("FAIL freeze_hold i=%0d got=%0d/%0d want=1/0",
                         i, stall, stall_count); end
        end
        freeze = 1'b0;
        tick();
        n_cmp++; if (stall_count !== 8'd1) begin n_bad++;
            $display("FAIL unfreeze_count got=%0d want=1", stall_count); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++;
            $display("FAIL unfreeze_stall got=%0d want=0", stall); end
    endtask

    task automatic test_random();
        int ea;
        int eb;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            set_id($urandom_range(0, 7) != 0,
                   $urandom_range(0, 3), 1'($urandom),
                   $urandom_range(0, 3), 1'($urandom),
                   $urandom_range(0, 3), 1'($urandom),
                   $urandom_range(0, 2) == 0);
            flush  = $urandom_range(0, 7) == 0;
            freeze = $urandom_range(0, 7) == 0;
            #1;
            ea = m_fwd(pipe[0].rs1, pipe[0].u1);
            eb = m_fwd(pipe[0].rs2, pipe[0].u2);
            n_cmp++; if (int'(fwd_a) != ea) begin n_bad++;
                $display("FAIL rnd_fwd_a i=%0d got=%0d want=%0d",
                         i, fwd_a, ea); end
            n_cmp++; if (int'(fwd_b) != eb) begin n_bad++;
                $display("FAIL rnd_fwd_b i=%0d got=%0d want=%0d",
                         i, fwd_b, eb); end
            n_cmp++; if (stall !== m_stall()) begin n_bad++;
                $display("FAIL rnd_stall i=%0d got=%0d want=%0d",
                         i, stall, m_stall()); end
            n_cmp++; if (int'(stall_count) != m_cnt) begin n_bad++;
                $display("FAIL rnd_count i=%0d got=%0d want=%0d",
                         i, stall_count, m_cnt); end
            tick();
        end
        flush  = 1'b0;
        freeze = 1'b0;
    endtask

    // lw x8,0(x8) repeated: stalls every other cycle
    task automatic test_saturation();
        do_reset();
        set_id(1, 8, 1, 0, 0, 8, 1, 1);
        repeat (2 * (CMAX + 1) + 10) tick();
        n_cmp++; if (stall_count !== 8'(CMAX)) begin n_bad++;
            $display("FAIL sat_count got=%0d want=%0d",
                     stall_count, CMAX); end
        n_cmp++; if (int'(stall_count) != m_cnt) begin n_bad++;
            $display("FAIL sat_model got=%0d want=%0d",
                     stall_count, m_cnt); end
        if (!m_stall()) tick();
        n_cmp++; if (stall !== 1'b1) begin n_bad++;
            $display("FAIL sat_stall got=%0d want=1", stall); end
        tick();
        n_cmp++; if (stall_count !== 8'(CMAX)) begin n_bad++;
            $display("FAIL sat_hold got=%0d want=%0d",
                     stall_count, CMAX); end
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++;
            $display("FAIL arst_stall got=%0d want=0", stall); end
        n_cmp++; if (stall_count !== '0) begin n_bad++;
            $display("FAIL arst_count got=%0d want=0", stall_count); end
        n_cmp++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin n_bad++;
            $display("FAIL arst_fwd got=%0d/%0d want=0/0",
                     fwd_a, fwd_b); end
        model_clear();
        rst_n = 1'b1;
        idle();
    endtask

    initial begin
        rst_n  = 1'b0;
        flush  = 1'b0;
        freeze = 1'b0;
        idle();
        model_clear();
        #3;
        test_reset();
        test_alu_fwd();
        test_wb_fwd();
        test_load_use();
        test_x0();
        test_flush_freeze();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
